// File: rtl/oam_dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : oam_dma_arbiter_pkg
//  Purpose  : Shared constants, DMA state encoding and address helpers for
//             the OAM DMA arbiter and its sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package oam_dma_arbiter_pkg;

  localparam logic [15:0] MMIO_DMA        = 16'hFF46;
  localparam logic [15:0] MEM_OAM_START   = 16'hFE00;
  localparam logic [15:0] MEM_HRAM_START  = 16'hFF80;
  localparam logic [15:0] MEM_HRAM_END    = 16'hFFFE;
  localparam int          DMA_LEN_DEFAULT = 160;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_START = 3'd1,
    DMA_RD    = 3'd2,
    DMA_RDW   = 3'd3,
    DMA_WR    = 3'd4,
    DMA_GAP   = 3'd5
  } dma_state_e;

  // Pages E0..FF are the echo of WRAM; read the real WRAM page instead.
  function automatic logic [7:0] dma_read_page(input logic [7:0] src_hi);
    return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
  endfunction

  function automatic logic hram_hit(input logic [15:0] a);
    return (a >= MEM_HRAM_START) && (a <= MEM_HRAM_END);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_seq.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma_seq
//  Purpose  : OAM DMA sequencer. Walks START -> (RD, RDW, WR, GAP) x DMA_LEN,
//             keeps the byte index and the read-data latch, and presents the
//             DMA-side bus request. A start strobe restarts from index 0 at
//             any point, abandoning the byte in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module oam_dma_seq
  import oam_dma_arbiter_pkg::*;
#(
  parameter int          DMA_LEN   = DMA_LEN_DEFAULT,
  parameter int          START_DLY = 1,
  parameter logic [15:0] OAM_BASE  = MEM_OAM_START
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  page_i,
  input  logic [7:0]  bus_din_i,
  output logic [15:0] dma_a_o,
  output logic [7:0]  dma_dout_o,
  output logic        dma_we_o,
  output logic        dma_re_o,
  output logic        dma_own_o,
  output logic        active_o
);

  localparam int         DLY_W    = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int         DLY_LSTI = (START_DLY > 0) ? (START_DLY - 1) : 0;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_LSTI);
  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

  dma_state_e       state_q, state_d;
  logic [7:0]       idx_q,   idx_d;
  logic [7:0]       latch_q, latch_d;
  logic [DLY_W-1:0] dly_q,   dly_d;

  // State, index, start-delay counter and data latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMA_IDLE;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      dly_q   <= dly_d;
    end
  end

  // Next-state logic and DMA-side bus request; a start strobe overrides all.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    latch_d    = latch_q;
    dly_d      = dly_q;
    dma_a_o    = {page_i, idx_q};
    dma_dout_o = latch_q;
    dma_we_o   = 1'b0;
    dma_re_o   = 1'b0;
    dma_own_o  = 1'b0;

    case (state_q)
      DMA_IDLE: begin
      end
      DMA_START: begin
        if (dly_q == DLY_LAST) state_d = DMA_RD;
        else                   dly_d   = dly_q + 1'b1;
      end
      DMA_RD: begin
        dma_own_o = 1'b1;
        dma_re_o  = 1'b1;
        state_d   = DMA_RDW;
      end
      DMA_RDW: begin
        // Read data arrives one cycle after the read strobe.
        dma_own_o = 1'b1;
        latch_d   = bus_din_i;
        state_d   = DMA_WR;
      end
      DMA_WR: begin
        dma_own_o = 1'b1;
        dma_we_o  = 1'b1;
        dma_a_o   = OAM_BASE + {8'h00, idx_q};
        state_d   = DMA_GAP;
      end
      DMA_GAP: begin
        if (idx_q == IDX_LAST) begin
          state_d = DMA_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DMA_RD;
        end
      end
      default: state_d = DMA_IDLE;
    endcase

    if (start_i) begin
      idx_d   = 8'h00;
      dly_d   = '0;
      state_d = (START_DLY == 0) ? DMA_RD : DMA_START;
    end
  end

  assign active_o = (state_q != DMA_IDLE);

endmodule
`default_nettype wire

// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma_arbiter
//  Purpose  : Owns the main bus between the CPU and the OAM DMA engine. Holds
//             the FF46 source-page register, stalls colliding CPU accesses and
//             muxes the DMA or CPU request onto the bus.
//  Config   : DMA_HRAM_PASS_EN - when defined, CPU accesses to FF80..FFFE
//             pass while DMA is active but not owning the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int          DMA_LEN   = DMA_LEN_DEFAULT,
  parameter int          START_DLY = 1,
  parameter logic [15:0] OAM_BASE  = MEM_OAM_START
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic        cpu_stall,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [7:0]  bus_din,
  output logic [7:0]  reg_dout,
  output logic        dma_active
);

  logic [7:0]  src_hi_q, src_hi_d;
  logic        ff46_sel;
  logic        ff46_wr;
  logic        cpu_allowed;
  logic [15:0] dma_a;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        dma_re;
  logic        dma_own;

  assign ff46_sel = (cpu_a == MMIO_DMA);
  assign ff46_wr  = ff46_sel & cpu_we;
  assign src_hi_d = ff46_wr ? cpu_dout : src_hi_q;

  // Source page register, readable back at FF46.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) src_hi_q <= 8'h00;
    else     src_hi_q <= src_hi_d;
  end

  assign reg_dout = src_hi_q;

  oam_dma_seq #(
    .DMA_LEN   (DMA_LEN),
    .START_DLY (START_DLY),
    .OAM_BASE  (OAM_BASE)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start_i    (ff46_wr),
    .page_i     (dma_read_page(src_hi_q)),
    .bus_din_i  (bus_din),
    .dma_a_o    (dma_a),
    .dma_dout_o (dma_dout),
    .dma_we_o   (dma_we),
    .dma_re_o   (dma_re),
    .dma_own_o  (dma_own),
    .active_o   (dma_active)
  );

`ifdef DMA_HRAM_PASS_EN
  assign cpu_allowed = hram_hit(cpu_a) & ~dma_own;
`else
  assign cpu_allowed = 1'b0;
`endif

  assign cpu_stall = dma_active & (cpu_we | cpu_re) & ~cpu_allowed & ~ff46_sel;

  // Bus mux: DMA while it owns the bus, otherwise CPU with stalled strobes dropped.
  always_comb begin
    bus_a    = cpu_a;
    bus_dout = cpu_dout;
    bus_we   = cpu_we & ~cpu_stall;
    bus_re   = cpu_re & ~cpu_stall;
    if (dma_own) begin
      bus_a    = dma_a;
      bus_dout = dma_dout;
      bus_we   = dma_we;
      bus_re   = dma_re;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oam_dma_arbiter
//  Purpose  : Directed self-checking bench for oam_dma_arbiter with a simple
//             64 KiB bus memory model (read data one cycle after bus_re).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_stall;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_din;
  logic [7:0]  reg_dout;
  logic        dma_active;

  int checks   = 0;
  int failures = 0;

`ifdef DMA_HRAM_PASS_EN
  localparam bit HP = 1'b1;
`else
  localparam bit HP = 1'b0;
`endif

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_stall  (cpu_stall),
    .bus_a      (bus_a),
    .bus_dout   (bus_dout),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_din    (bus_din),
    .reg_dout   (reg_dout),
    .dma_active (dma_active)
  );

  // Bus memory model plus a backdoor load port used only while the bus is quiet.
  logic [7:0]  mem [0:65535];
  logic [7:0]  rdata = 8'h00;
  logic        ld_we = 1'b0;
  logic [15:0] ld_a  = 16'h0000;
  logic [7:0]  ld_d  = 8'h00;

  always @(posedge clk) begin
    if (bus_re) rdata <= mem[bus_a];
    if (bus_we)     mem[bus_a] <= bus_dout;
    else if (ld_we) mem[ld_a]  <= ld_d;
  end
  assign bus_din = rdata;

  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'hFF;
      2:       return 8'(i) ^ 8'h5A;
      3:       return ~8'(i);
      4:       return 8'hEE;
      default: return 8'hA5;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] base, input int mode, input int len);
    for (int i = 0; i < len; i++) begin
      ld_we = 1'b1;
      ld_a  = base + 16'(i);
      ld_d  = pat(mode, i);
      step();
    end
    ld_we = 1'b0;
  endtask

  task automatic ff46_write(input logic [7:0] v);
    cpu_a    = 16'hFF46;
    cpu_dout = v;
    cpu_we   = 1'b1;
    cpu_re   = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL ff46_no_stall: actual=%0b required=0", cpu_stall);
    end
    step();
    cpu_we = 1'b0;
    cpu_a  = 16'h0000;
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (dma_active === 1'b1 && n < 3000) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_a = 16'h1234; cpu_dout = 8'h00; cpu_we = 1'b0; cpu_re = 1'b1;
    step(); step();
    checks++;
    if (dma_active !== 1'b0 || cpu_stall !== 1'b0 || reg_dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: actual active=%0b stall=%0b reg=%0h required 0/0/00",
               dma_active, cpu_stall, reg_dout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_a !== 16'h1234 || bus_re !== 1'b1 || bus_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_passthru: actual a=%0h re=%0b we=%0b required 1234/1/0",
               bus_a, bus_re, bus_we);
    end
    cpu_re = 1'b0;
    cpu_a  = 16'h0000;
    #1;
  endtask

  task automatic test_basic();
    int n, errs;
    fill(16'hC100, 0, 160);
    fill(16'hFE00, 1, 160);
    ff46_write(8'hC1);
    checks++;
    if (reg_dout !== 8'hC1 || dma_active !== 1'b1 || bus_re !== 1'b0) begin
      failures++;
      $display("FAIL basic_start: actual reg=%0h active=%0b re=%0b required C1/1/0",
               reg_dout, dma_active, bus_re);
    end
    step();
    checks++;
    if (bus_a !== 16'hC100 || bus_re !== 1'b1) begin
      failures++;
      $display("FAIL basic_first_rd: actual a=%0h re=%0b required C100/1", bus_a, bus_re);
    end
    step(); step();
    checks++;
    if (bus_a !== 16'hFE00 || bus_we !== 1'b1 || bus_dout !== 8'h00) begin
      failures++;
      $display("FAIL basic_first_wr: actual a=%0h we=%0b d=%0h required FE00/1/00",
               bus_a, bus_we, bus_dout);
    end
    wait_done(n);
    checks++;
    if (n + 3 !== 641) begin
      failures++;
      $display("FAIL basic_active_len: actual=%0d required=641", n + 3);
    end
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== pat(0, i)) errs++;
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL basic_oam: actual bad_bytes=%0d required=0", errs);
    end
  endtask

  task automatic test_stall();
    int cnt, bad, leak;
    fill(16'hC000, 5, 1);
    ff46_write(8'hC1);
    cpu_a = 16'hC000;
    cpu_re = 1'b1;
    #1;
    cnt = 0; bad = 0; leak = 0;
    while (dma_active === 1'b1 && cnt < 3000) begin
      if (cpu_stall !== 1'b1) bad++;
      if (bus_a == 16'hC000 && bus_re) leak++;
      cnt++;
      step();
    end
    checks++;
    if (bad !== 0 || leak !== 0 || cnt !== 641) begin
      failures++;
      $display("FAIL stall_window: actual unstalled=%0d leaked=%0d cycles=%0d required 0/0/641",
               bad, leak, cnt);
    end
    checks++;
    if (cpu_stall !== 1'b0 || bus_re !== 1'b1 || bus_a !== 16'hC000) begin
      failures++;
      $display("FAIL stall_release: actual stall=%0b re=%0b a=%0h required 0/1/C000",
               cpu_stall, bus_re, bus_a);
    end
    step();
    cpu_re = 1'b0;
    cpu_a  = 16'h0000;
    #1;
    checks++;
    if (bus_din !== 8'hA5) begin
      failures++;
      $display("FAIL stall_read_data: actual=%0h required=A5", bus_din);
    end
  endtask

  task automatic test_hram();
    int n;
    ff46_write(8'hC1);
    cpu_a = 16'hFF90; cpu_dout = 8'h55; cpu_we = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== !HP || bus_we !== HP) begin
      failures++;
      $display("FAIL hram_start: actual stall=%0b we=%0b required %0b/%0b",
               cpu_stall, bus_we, !HP, HP);
    end
    step(); step(); step();
    checks++;
    if (cpu_stall !== 1'b1 || bus_we !== 1'b1 || bus_a !== 16'hFE00) begin
      failures++;
      $display("FAIL hram_wr_cycle: actual stall=%0b we=%0b a=%0h required 1/1/FE00",
               cpu_stall, bus_we, bus_a);
    end
    step();
    checks++;
    if (cpu_stall !== !HP || bus_we !== HP || bus_a !== 16'hFF90) begin
      failures++;
      $display("FAIL hram_gap: actual stall=%0b we=%0b a=%0h required %0b/%0b/FF90",
               cpu_stall, bus_we, bus_a, !HP, HP);
    end
    cpu_we = 1'b0;
    cpu_a  = 16'h0000;
    #1;
    wait_done(n);
  endtask

  task automatic test_fold();
    int n, errs;
    fill(16'hC200, 2, 160);
    fill(16'hFE00, 1, 160);
    ff46_write(8'hE2);
    checks++;
    if (reg_dout !== 8'hE2) begin
      failures++;
      $display("FAIL fold_readback: actual=%0h required=E2", reg_dout);
    end
    step();
    checks++;
    if (bus_a !== 16'hC200 || bus_re !== 1'b1) begin
      failures++;
      $display("FAIL fold_rd_addr: actual a=%0h re=%0b required C200/1", bus_a, bus_re);
    end
    wait_done(n);
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== pat(2, i)) errs++;
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL fold_oam: actual bad_bytes=%0d required=0", errs);
    end
  endtask

  task automatic test_restart();
    int n, errs, k;
    fill(16'hC300, 3, 160);
    fill(16'hFE00, 1, 160);
    ff46_write(8'hC1);
    k = 0;
    while (!(bus_re === 1'b1 && bus_a === 16'hC132) && k < 1000) begin
      k++;
      step();
    end
    checks++;
    if (k >= 1000) begin
      failures++;
      $display("FAIL restart_find_idx50: actual timeout required read of C132");
    end
    cpu_a = 16'hFF46; cpu_dout = 8'hC3; cpu_we = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL restart_no_stall: actual=%0b required=0", cpu_stall);
    end
    step();
    cpu_we = 1'b0;
    cpu_a  = 16'h0000;
    #1;
    checks++;
    if (dma_active !== 1'b1 || bus_we !== 1'b0 || bus_re !== 1'b0 || reg_dout !== 8'hC3) begin
      failures++;
      $display("FAIL restart_start: actual active=%0b we=%0b re=%0b reg=%0h required 1/0/0/C3",
               dma_active, bus_we, bus_re, reg_dout);
    end
    wait_done(n);
    checks++;
    if (n !== 641) begin
      failures++;
      $display("FAIL restart_len: actual=%0d required=641", n);
    end
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== pat(3, i)) errs++;
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL restart_oam: actual bad_bytes=%0d required=0", errs);
    end
  endtask

  task automatic test_reset_mid();
    int k, errs_lo, errs_hi;
    fill(16'hFE00, 4, 160);
    ff46_write(8'hC1);
    k = 0;
    while (!(bus_we === 1'b1 && bus_a === 16'hFE50) && k < 1000) begin
      k++;
      step();
    end
    checks++;
    if (k >= 1000) begin
      failures++;
      $display("FAIL rstmid_find_idx80: actual timeout required write of FE50");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dma_active !== 1'b0 || bus_we !== 1'b0 || reg_dout !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_abort: actual active=%0b we=%0b reg=%0h required 0/0/00",
               dma_active, bus_we, reg_dout);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 200; i++) step();
    errs_lo = 0;
    errs_hi = 0;
    for (int i = 0; i < 80; i++)   if (mem[16'hFE00 + 16'(i)] !== pat(0, i)) errs_lo++;
    for (int i = 80; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== 8'hEE)     errs_hi++;
    checks++;
    if (errs_lo !== 0 || errs_hi !== 0 || dma_active !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_oam: actual bad_lo=%0d bad_hi=%0d active=%0b required 0/0/0",
               errs_lo, errs_hi, dma_active);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hram();
    test_fold();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
